// File: rtl/noc_out_port_arbiter_if.sv
// Channel bundle between the NREQ routing blocks, the shared output buffer
// and the downstream link of one router output port.
interface noc_out_port_arbiter_if #(
  parameter int WIDTH = 11,
  parameter int NREQ  = 3,
  parameter int GW    = $clog2(NREQ)
);
  logic [NREQ-1:0]       in_valid;
  logic [NREQ*WIDTH-1:0] in_data;
  logic [NREQ-1:0]       in_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic                  out_ready;
  logic [GW-1:0]         grant_id;
  logic [15:0]           pkt_count;

  modport master (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, grant_id, pkt_count
  );

  modport slave (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, grant_id, pkt_count
  );
endinterface

// File: rtl/noc_out_port_arbiter.sv
// Round-robin arbiter feeding a one-entry output buffer, with a programmable
// recovery gap after every downstream handshake.
module noc_out_port_arbiter #(
  parameter int WIDTH   = 11,
  parameter int NREQ    = 3,
  parameter int GAP_CYC = 0,
  parameter int GW      = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  noc_out_port_arbiter_if.master arb_io
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} arbState_e;

  arbState_e        state_q, state_d;
  logic [GW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] outData_q, outData_d;
  logic [GW-1:0]    grantId_q, grantId_d;
  logic [3:0]       gapCnt_q, gapCnt_d;
  logic [15:0]      pktCount_q, pktCount_d;

  logic             winnerValid;
  logic [GW-1:0]    winnerIdx;
  logic [GW-1:0]    cand;
  logic [NREQ-1:0]  readyVec;

  // Search starts one past the last winner so a continuously valid requester
  // waits at most NREQ-1 grants.
  always_comb begin
    winnerValid = 1'b0;
    winnerIdx   = '0;
    cand        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = GW'((int'(ptr_q) + k) % NREQ);
      if (!winnerValid && arb_io.in_valid[cand]) begin
        winnerValid = 1'b1;
        winnerIdx   = cand;
      end
    end
  end

  always_comb begin
    readyVec            = '0;
    readyVec[winnerIdx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= GW'(NREQ - 1);
      outData_q  <= '0;
      grantId_q  <= '0;
      gapCnt_q   <= '0;
      pktCount_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      outData_q  <= outData_d;
      grantId_q  <= grantId_d;
      gapCnt_q   <= gapCnt_d;
      pktCount_q <= pktCount_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    outData_d  = outData_q;
    grantId_d  = grantId_q;
    gapCnt_d   = gapCnt_q;
    pktCount_d = pktCount_q;
    case (state_q)
      IDLE: begin
        if (winnerValid) begin
          outData_d = arb_io.in_data[winnerIdx*WIDTH +: WIDTH];
          grantId_d = winnerIdx;
          ptr_d     = winnerIdx;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (arb_io.out_ready) begin
          pktCount_d = pktCount_q + 16'd1;
          if (GAP_CYC > 0) begin
            state_d  = GAP;
            gapCnt_d = 4'(GAP_CYC - 1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gapCnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          gapCnt_d = gapCnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // rst_n gates in_ready directly so no requester sees a grant during reset.
  always_comb begin
    arb_io.in_ready  = '0;
    arb_io.out_valid = (state_q == SEND);
    if (rst_n && (state_q == IDLE) && winnerValid) begin
      arb_io.in_ready = readyVec;
    end
  end

  assign arb_io.out_data  = outData_q;
  assign arb_io.grant_id  = grantId_q;
  assign arb_io.pkt_count = pktCount_q;

endmodule

// File: tb/tb_noc_out_port_arbiter.sv
// Directed bench: one arbiter instance with no recovery gap and one with a
// three-cycle gap, sharing clock and reset.
module tb_noc_out_port_arbiter;

  localparam int WIDTH = 11;
  localparam int NREQ  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  noc_out_port_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) ifA ();
  noc_out_port_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) ifB ();

  noc_out_port_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .GAP_CYC(0)) dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .arb_io(ifA)
  );

  noc_out_port_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .GAP_CYC(3)) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .arb_io(ifB)
  );

  // Leaves the bench on a falling edge with reset just released.
  task automatic doReset();
    @(negedge clk);
    rst_n         = 1'b0;
    ifA.in_valid  = '0;
    ifA.in_data   = '0;
    ifA.out_ready = 1'b0;
    ifB.in_valid  = '0;
    ifB.in_data   = '0;
    ifB.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    ifA.in_valid  = 3'b111;
    ifA.in_data   = {11'h333, 11'h222, 11'h111};
    ifA.out_ready = 1'b1;
    ifB.in_valid  = '0;
    ifB.in_data   = '0;
    ifB.out_ready = 1'b0;
    #2;
    checks++; if (ifA.in_ready !== 3'b000) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 000", ifA.in_ready); end
    checks++; if (ifA.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", ifA.out_valid); end
    checks++; if (ifA.out_data !== 11'h000) begin errors++; $display("[TB] FAIL reset_out_data: got %h expected 000", ifA.out_data); end
    checks++; if (ifA.grant_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_grant_id: got %0d expected 0", ifA.grant_id); end
    checks++; if (ifA.pkt_count !== 16'h0000) begin errors++; $display("[TB] FAIL reset_pkt_count: got %h expected 0000", ifA.pkt_count); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (ifA.in_ready !== 3'b001) begin errors++; $display("[TB] FAIL reset_first_grant: got %b expected 001", ifA.in_ready); end
    @(negedge clk);
    ifA.in_valid = '0;
    #1;
    checks++; if (ifA.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL reset_first_valid: got %b expected 1", ifA.out_valid); end
    checks++; if (ifA.grant_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_first_gid: got %0d expected 0", ifA.grant_id); end
    checks++; if (ifA.out_data !== 11'h111) begin errors++; $display("[TB] FAIL reset_first_data: got %h expected 111", ifA.out_data); end
  endtask

  task automatic test_single();
    doReset();
    ifA.in_valid  = 3'b010;
    ifA.in_data   = {11'h7FF, 11'h2A5, 11'h0F0};
    ifA.out_ready = 1'b1;
    #1;
    checks++; if (ifA.in_ready !== 3'b010) begin errors++; $display("[TB] FAIL single_c0_ready: got %b expected 010", ifA.in_ready); end
    @(negedge clk);
    ifA.in_valid = '0;
    #1;
    checks++; if (ifA.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_c1_valid: got %b expected 1", ifA.out_valid); end
    checks++; if (ifA.out_data !== 11'h2A5) begin errors++; $display("[TB] FAIL single_c1_data: got %h expected 2a5", ifA.out_data); end
    checks++; if (ifA.grant_id !== 2'd1) begin errors++; $display("[TB] FAIL single_c1_gid: got %0d expected 1", ifA.grant_id); end
    checks++; if (ifA.pkt_count !== 16'd0) begin errors++; $display("[TB] FAIL single_c1_count: got %0d expected 0", ifA.pkt_count); end
    @(negedge clk);
    #1;
    checks++; if (ifA.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_c2_valid: got %b expected 0", ifA.out_valid); end
    checks++; if (ifA.pkt_count !== 16'd1) begin errors++; $display("[TB] FAIL single_c2_count: got %0d expected 1", ifA.pkt_count); end
    ifA.in_valid = 3'b001;
    #1;
    checks++; if (ifA.in_ready !== 3'b001) begin errors++; $display("[TB] FAIL single_c2_idle: got %b expected 001", ifA.in_ready); end
    ifA.in_valid = '0;
  endtask

  task automatic test_fairness();
    logic [WIDTH-1:0] fdata [3];
    logic [NREQ-1:0]  expReady;
    logic [1:0]       expGid;
    fdata[0] = 11'h101;
    fdata[1] = 11'h202;
    fdata[2] = 11'h404;
    doReset();
    ifA.in_valid  = 3'b111;
    ifA.in_data   = {fdata[2], fdata[1], fdata[0]};
    ifA.out_ready = 1'b1;
    for (int g = 0; g < 6; g++) begin
      expGid   = 2'(g % 3);
      expReady = 3'(1 << (g % 3));
      #1;
      checks++; if (ifA.in_ready !== expReady) begin errors++; $display("[TB] FAIL fair_ready[%0d]: got %b expected %b", g, ifA.in_ready, expReady); end
      @(negedge clk);
      #1;
      checks++; if (ifA.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL fair_valid[%0d]: got %b expected 1", g, ifA.out_valid); end
      checks++; if (ifA.grant_id !== expGid) begin errors++; $display("[TB] FAIL fair_gid[%0d]: got %0d expected %0d", g, ifA.grant_id, expGid); end
      checks++; if (ifA.out_data !== fdata[expGid]) begin errors++; $display("[TB] FAIL fair_data[%0d]: got %h expected %h", g, ifA.out_data, fdata[expGid]); end
      checks++; if (ifA.pkt_count !== 16'(g)) begin errors++; $display("[TB] FAIL fair_count[%0d]: got %0d expected %0d", g, ifA.pkt_count, g); end
      @(negedge clk);
    end
    #1;
    checks++; if (ifA.pkt_count !== 16'd6) begin errors++; $display("[TB] FAIL fair_total: got %0d expected 6", ifA.pkt_count); end
    ifA.in_valid = '0;
  endtask

  task automatic test_backpressure();
    doReset();
    ifA.in_valid  = 3'b001;
    ifA.in_data   = {11'h0CC, 11'h0AA, 11'h155};
    ifA.out_ready = 1'b0;
    #1;
    checks++; if (ifA.in_ready !== 3'b001) begin errors++; $display("[TB] FAIL bp_accept: got %b expected 001", ifA.in_ready); end
    @(negedge clk);
    ifA.in_valid = 3'b110;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (ifA.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid[%0d]: got %b expected 1", c, ifA.out_valid); end
      checks++; if (ifA.out_data !== 11'h155) begin errors++; $display("[TB] FAIL bp_data[%0d]: got %h expected 155", c, ifA.out_data); end
      checks++; if (ifA.grant_id !== 2'd0) begin errors++; $display("[TB] FAIL bp_gid[%0d]: got %0d expected 0", c, ifA.grant_id); end
      checks++; if (ifA.in_ready !== 3'b000) begin errors++; $display("[TB] FAIL bp_ready[%0d]: got %b expected 000", c, ifA.in_ready); end
      checks++; if (ifA.pkt_count !== 16'd0) begin errors++; $display("[TB] FAIL bp_count[%0d]: got %0d expected 0", c, ifA.pkt_count); end
      @(negedge clk);
    end
    ifA.out_ready = 1'b1;
    #1;
    checks++; if (ifA.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_valid: got %b expected 1", ifA.out_valid); end
    @(negedge clk);
    #1;
    checks++; if (ifA.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_after_valid: got %b expected 0", ifA.out_valid); end
    checks++; if (ifA.pkt_count !== 16'd1) begin errors++; $display("[TB] FAIL bp_after_count: got %0d expected 1", ifA.pkt_count); end
    checks++; if (ifA.in_ready !== 3'b010) begin errors++; $display("[TB] FAIL bp_next_grant: got %b expected 010", ifA.in_ready); end
    ifA.in_valid = '0;
  endtask

  task automatic test_gap();
    logic [NREQ-1:0] expReady;
    logic            expValid;
    doReset();
    ifB.in_valid  = 3'b100;
    ifB.in_data   = {11'h3C7, 11'h000, 11'h000};
    ifB.out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      expReady = (c % 5 == 0) ? 3'b100 : 3'b000;
      expValid = (c % 5 == 1);
      #1;
      checks++; if (ifB.in_ready !== expReady) begin errors++; $display("[TB] FAIL gap_ready[%0d]: got %b expected %b", c, ifB.in_ready, expReady); end
      checks++; if (ifB.out_valid !== expValid) begin errors++; $display("[TB] FAIL gap_valid[%0d]: got %b expected %b", c, ifB.out_valid, expValid); end
      @(negedge clk);
    end
    #1;
    checks++; if (ifB.pkt_count !== 16'd3) begin errors++; $display("[TB] FAIL gap_count: got %0d expected 3", ifB.pkt_count); end
    checks++; if (ifB.out_data !== 11'h3C7) begin errors++; $display("[TB] FAIL gap_data: got %h expected 3c7", ifB.out_data); end
    ifB.in_valid = '0;
  endtask

  task automatic test_async_reset();
    doReset();
    ifA.in_valid  = 3'b001;
    ifA.in_data   = {11'h001, 11'h002, 11'h7E1};
    ifA.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ifA.out_ready = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (ifA.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL areset_pre_valid: got %b expected 1", ifA.out_valid); end
    checks++; if (ifA.pkt_count !== 16'd1) begin errors++; $display("[TB] FAIL areset_pre_count: got %0d expected 1", ifA.pkt_count); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (ifA.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL areset_valid: got %b expected 0", ifA.out_valid); end
    checks++; if (ifA.pkt_count !== 16'd0) begin errors++; $display("[TB] FAIL areset_count: got %0d expected 0", ifA.pkt_count); end
    checks++; if (ifA.out_data !== 11'h000) begin errors++; $display("[TB] FAIL areset_data: got %h expected 000", ifA.out_data); end
    checks++; if (ifA.in_ready !== 3'b000) begin errors++; $display("[TB] FAIL areset_ready: got %b expected 000", ifA.in_ready); end
    @(negedge clk);
    rst_n         = 1'b1;
    ifA.in_valid  = 3'b111;
    ifA.out_ready = 1'b1;
    #1;
    checks++; if (ifA.in_ready !== 3'b001) begin errors++; $display("[TB] FAIL areset_ptr: got %b expected 001", ifA.in_ready); end
    @(negedge clk);
    ifA.in_valid = '0;
    @(negedge clk);
    #1;
    checks++; if (ifA.pkt_count !== 16'd1) begin errors++; $display("[TB] FAIL areset_recount: got %0d expected 1", ifA.pkt_count); end
  endtask

  task automatic test_wrap();
    doReset();
    ifA.in_valid  = 3'b111;
    ifA.in_data   = {11'h123, 11'h456, 11'h789};
    ifA.out_ready = 1'b1;
    repeat (2 * 65535) @(negedge clk);
    #1;
    checks++; if (ifA.pkt_count !== 16'hFFFF) begin errors++; $display("[TB] FAIL wrap_max: got %h expected ffff", ifA.pkt_count); end
    repeat (2) @(negedge clk);
    #1;
    checks++; if (ifA.pkt_count !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_zero: got %h expected 0000", ifA.pkt_count); end
    ifA.in_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_gap();
    test_async_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_out_port_arbiter.md
# noc_out_port_arbiter

Clocked round-robin arbiter that shares one router output port between the NREQ routing-logic blocks of a NoC node. Each routing block (one per incoming direction) presents a resolved flit on a valid/ready channel. The arbiter grants one requester at a time and latches that flit into a one-entry output buffer. It holds the flit on the output channel until the downstream link accepts it, then enforces a programmable recovery gap before the next grant.

## Interface
Parameters:
- WIDTH, 11, flit width; bit 0 = flit type, [3:1] = destination router, [WIDTH-1:4] = payload; carried opaquely.
- NREQ, 3, number of requesters; legal range 2..4.
- GAP_CYC, 0, idle cycles enforced after each output handshake before the next grant; legal range 0..15.
- GW, $clog2(NREQ), width of grant index.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  NREQ  requester i holds a flit.
- in_data  in  NREQ*WIDTH  flit of requester i in bits [i*WIDTH +: WIDTH].
- in_ready  out  NREQ  one-hot or zero; an input transfer on i occurs at an edge where in_valid[i] && in_ready[i].
- out_valid  out  1  output buffer holds a flit.
- out_data  out  WIDTH  buffered flit.
- out_ready  in  1  downstream accepts; an output transfer occurs at an edge where out_valid && out_ready.
- grant_id  out  GW  index of the requester whose flit is buffered; meaningful only while out_valid=1.
- pkt_count  out  16  count of output transfers since reset; wraps.

## Operation
- State machine: IDLE, SEND, GAP.
- IDLE:
  - Winner = first i with in_valid[i]=1, searching ptr+1, ptr+2, … modulo NREQ.
  - in_ready[winner]=1 combinationally; all other in_ready bits are 0. If no in_valid bit is set, in_ready=0.
  - On the transfer edge: out_data <= in_data[winner], grant_id <= winner, ptr <= winner, state -> SEND.
- SEND:
  - out_valid=1; in_ready=0.
  - out_data and grant_id are held stable, including under backpressure.
  - On the output transfer edge: pkt_count <= pkt_count+1 (0xFFFF wraps to 0x0000).
  - Next state is GAP if GAP_CYC>0, with gap_cnt <= GAP_CYC-1; otherwise IDLE.
- GAP:
  - out_valid=0; in_ready=0.
  - gap_cnt decrements each cycle. When gap_cnt==0, state -> IDLE.
- Round-robin fairness: a requester that is continuously valid waits at most NREQ-1 grants.
- A requester may drop in_valid before it is granted; it is then simply skipped. Flits are never duplicated and never dropped.
- The arbiter does not inspect destination bits. Routing is already resolved upstream.

## Timing
- Reset (asserted asynchronously, released synchronously to clk by the top level):
  - state=IDLE, ptr=NREQ-1 (requester 0 has first priority).
  - out_valid=0, out_data=0, grant_id=0, pkt_count=0, gap_cnt=0.
  - in_ready is all zeros while rst_n=0.
- Reset mid-operation: out_valid falls immediately without waiting for clk. The buffered flit is discarded and not counted. ptr returns to NREQ-1.
- Latency:
  - Input transfer at edge k gives out_valid=1 in the cycle after edge k.
  - With out_ready=1, the output transfer happens at edge k+1.
- Throughput: one flit per 2+GAP_CYC cycles with no backpressure.
- Simultaneous events:
  - A new in_valid arriving in the same cycle as an output transfer is not granted until the next IDLE cycle.
  - There is no bypass path and no double buffering.
- out_ready may toggle freely. out_valid never drops without a transfer, except on reset.
- in_ready depends only on state, ptr and in_valid. There is no combinational path from out_ready to in_ready.

## Test plan
- Reset value check:
  - Stimulus: assert rst_n=0 with in_valid=3'b111.
  - Required response: in_ready=0, out_valid=0, out_data=0, grant_id=0, pkt_count=0.
  - After release: first grant goes to requester 0.
- Single flit:
  - Stimulus: NREQ=3, GAP_CYC=0, out_ready=1; only requester 1 valid with data 11'h2A5.
  - Required response: in_ready=3'b010 in cycle 0; out_valid=1, out_data=11'h2A5, grant_id=1 in cycle 1; pkt_count=1 after edge 1; IDLE again in cycle 2.
- Fairness:
  - Stimulus: all three requesters continuously valid with out_ready=1.
  - Required response: grant_id sequence 0,1,2,0,1,2; one output transfer every 2 cycles.
- Backpressure:
  - Stimulus: flit 11'h155 buffered, out_ready held 0 for 5 cycles, then 1.
  - Required response: out_valid, out_data and grant_id stable for all 5 cycles; in_ready=0 throughout; output transfer on the 6th edge.
- Gap:
  - Stimulus: GAP_CYC=3, requester 2 continuously valid, out_ready=1.
  - Required response: accepts spaced exactly 5 cycles apart; in_ready=0 during the 3 GAP cycles.
- Async reset mid-SEND, then wrap:
  - Stimulus: drop rst_n between edges while out_valid=1.
  - Required response: out_valid falls before the next edge and pkt_count=0.
  - Wrap check: drive 65536 transfers; pkt_count returns to 0x0000.
